// File: rtl/uart_frame_parser_pkg.sv
// Shared types and helpers for the UART frame parser: SOF byte, FSM
// state encoding, error cause codes, CRC8 step and frame length decode.
package uart_frame_parser_pkg;

    localparam logic [7:0] SOF_BYTE      = 8'hA5;

    localparam logic [7:0] ERR_NONE      = 8'h00;
    localparam logic [7:0] ERR_BAD_SIZE  = 8'h01;
    localparam logic [7:0] ERR_CRC       = 8'h02;
    localparam logic [7:0] ERR_TIMEOUT   = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CRC,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_ERR
    } parser_state_e;

    // One byte of CRC8, poly 0x07, MSB first, no reflection.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // DATA phase length in bytes: (len+1) << size, 1..64.
    function automatic logic [6:0] frame_nbytes(input logic [7:0] c);
        return ({3'b000, c[3:0]} + 7'd1) << c[5:4];
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-stream input and command output bundle of the frame parser.
// master: the parser side. slave: RX FIFO / AXI master side.
interface uart_frame_parser_if #(
    parameter int MAX_BYTES = 64
);
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [7:0]  write_data [0:MAX_BYTES-1];
    logic        start_transaction;
    logic        transaction_done;
    logic        busy;
    logic        frame_error;
    logic [7:0]  error_code;
    logic [15:0] frame_count;

    modport master (
        input  rx_data, rx_valid, transaction_done,
        output rx_ready, cmd, addr, write_data, start_transaction,
               busy, frame_error, error_code, frame_count
    );

    modport slave (
        output rx_data, rx_valid, transaction_done,
        input  rx_ready, cmd, addr, write_data, start_transaction,
               busy, frame_error, error_code, frame_count
    );
endinterface

// File: rtl/uart_frame_parser_crc8.sv
// Byte-serial CRC8 accumulator (poly 0x07, init 0x00).
// Only instantiated when UART_FRAME_CRC_CHECK_EN is defined.
module uart_frame_parser_crc8
    import uart_frame_parser_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);
    logic [7:0] crc_q;

    // Restart on clear, otherwise fold in each enabled byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   crc_q <= 8'h00;
        else if (clr) crc_q <= 8'h00;
        else if (en)  crc_q <= crc8_update(crc_q, data);
    end

    assign crc = crc_q;
endmodule

// File: rtl/uart_frame_parser.sv
// UART-AXI bridge command stage: parses A5|CMD|ADDR(LE)|DATA|CRC8 frames,
// hands cmd/addr/write_data to the AXI master with a start pulse and waits
// for transaction_done.
// Optional: UART_FRAME_CRC_CHECK_EN enables the CRC comparison; without it
// the CRC byte is consumed and always treated as good.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_250_000,
    parameter int MAX_BYTES      = 64
) (
    input  logic clk,
    input  logic rst_n,
    uart_frame_parser_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    parser_state_e state_q, state_d;

    logic           rdy_en_q;       // keeps rx_ready low while in reset
    logic [6:0]     data_cnt_q;     // ADDR byte index, then DATA byte index
    logic [TW-1:0]  to_cnt_q;
    logic [7:0]     cmd_q;
    logic [31:0]    addr_q;
    logic [7:0]     wdata_q [0:MAX_BYTES-1];
    logic [7:0]     err_q;
    logic [15:0]    fcnt_q;

    logic           hs;
    logic           sof_hs;
    logic           in_frame;
    logic           timeout;
    logic           crc_ok;
    logic [6:0]     nbytes;
    logic [7:0]     err_d;
    logic           rx_ready_c, start_c, ferr_c, busy_c;

    assign hs       = bus.rx_valid & rx_ready_c;
    assign sof_hs   = hs && (state_q == ST_IDLE) && (bus.rx_data == SOF_BYTE);
    assign in_frame = state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_CRC};
    // The cycle that would bring the idle count to TIMEOUT_CYCLES; a
    // handshake in the same cycle takes priority.
    assign timeout  = in_frame && !hs && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign nbytes   = frame_nbytes(cmd_q);

`ifdef UART_FRAME_CRC_CHECK_EN
    logic [7:0] crc_q;
    logic       crc_en;

    assign crc_en = hs && (state_q inside {ST_CMD, ST_ADDR, ST_DATA});

    uart_frame_parser_crc8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sof_hs),
        .en    (crc_en),
        .data  (bus.rx_data),
        .crc   (crc_q)
    );

    assign crc_ok = (crc_q == bus.rx_data);
`else
    assign crc_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and error cause selection.
    always_comb begin
        state_d = state_q;
        err_d   = ERR_NONE;
        case (state_q)
            ST_IDLE: if (sof_hs) state_d = ST_CMD;
            ST_CMD: if (hs) begin
                if (bus.rx_data[5:4] == 2'b11) begin
                    state_d = ST_ERR;
                    err_d   = ERR_BAD_SIZE;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: if (hs && data_cnt_q == 7'd3) state_d = cmd_q[7] ? ST_CRC : ST_DATA;
            ST_DATA: if (hs && data_cnt_q == nbytes - 7'd1) state_d = ST_CRC;
            ST_CRC: if (hs) begin
                if (crc_ok) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_ERR;
                    err_d   = ERR_CRC;
                end
            end
            ST_ISSUE:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.transaction_done) state_d = ST_IDLE;
            ST_ERR:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        if (timeout) begin
            state_d = ST_ERR;
            err_d   = ERR_TIMEOUT;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        rx_ready_c = rdy_en_q && (state_q inside {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_CRC});
        start_c    = (state_q == ST_ISSUE);
        ferr_c     = (state_q == ST_ERR);
        busy_c     = (state_q != ST_IDLE);
    end

    // Frame datapath: field capture, byte counters, timeout, frame count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q   <= 1'b0;
            data_cnt_q <= '0;
            to_cnt_q   <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            err_q      <= '0;
            fcnt_q     <= '0;
            for (int i = 0; i < MAX_BYTES; i++) wdata_q[i] <= 8'h00;
        end else begin
            rdy_en_q <= 1'b1;

            if (hs || !in_frame) to_cnt_q <= '0;
            else                 to_cnt_q <= to_cnt_q + 1'b1;

            case (state_q)
                ST_IDLE: if (sof_hs) begin
                    err_q      <= ERR_NONE;
                    data_cnt_q <= '0;
                    for (int i = 0; i < MAX_BYTES; i++) wdata_q[i] <= 8'h00;
                end
                ST_CMD: if (hs) begin
                    cmd_q      <= bus.rx_data;
                    data_cnt_q <= '0;
                end
                ST_ADDR: if (hs) begin
                    addr_q[{data_cnt_q[1:0], 3'b000} +: 8] <= bus.rx_data;
                    data_cnt_q <= (data_cnt_q == 7'd3) ? 7'd0 : data_cnt_q + 7'd1;
                end
                ST_DATA: if (hs) begin
                    wdata_q[data_cnt_q[5:0]] <= bus.rx_data;
                    data_cnt_q <= data_cnt_q + 7'd1;
                end
                ST_ISSUE: fcnt_q <= fcnt_q + 16'd1;
                default: ;
            endcase

            if (state_d == ST_ERR && state_q != ST_ERR) err_q <= err_d;
        end
    end

    assign bus.rx_ready          = rx_ready_c;
    assign bus.start_transaction = start_c;
    assign bus.frame_error       = ferr_c;
    assign bus.busy              = busy_c;
    assign bus.cmd               = cmd_q;
    assign bus.addr              = addr_q;
    assign bus.write_data        = wdata_q;
    assign bus.error_code        = err_q;
    assign bus.frame_count       = fcnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected commands are queued as
// frames are driven and compared when start_transaction fires.
module tb_uart_frame_parser;

    typedef struct packed {
        logic [7:0]   cmd;
        logic [31:0]  addr;
        logic [511:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    int exp_fcnt = 0;

    txn_t exp_q[$];
    logic [7:0] frm[$];

    uart_frame_parser_if #(.MAX_BYTES(64)) bus ();

    uart_frame_parser #(.TIMEOUT_CYCLES(100), .MAX_BYTES(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang, need finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] wdata_packed();
        logic [511:0] r;
        for (int i = 0; i < 64; i++) r[8*i +: 8] = bus.write_data[i];
        return r;
    endfunction

    // Scoreboard: every start pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst_n && bus.start_transaction) begin
            txn_t e, a;
            n_start++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_start: got start with cmd=%02h, need no start", bus.cmd);
            end else begin
                e = exp_q.pop_front();
                a.cmd = bus.cmd; a.addr = bus.addr; a.data = wdata_packed();
                if (a !== e) begin
                    errors++;
                    $display("FAIL sb_txn: got cmd=%02h addr=%08h data=%h, need cmd=%02h addr=%08h data=%h",
                             a.cmd, a.addr, a.data, e.cmd, e.addr, e.data);
                end
            end
            checks++;
            if (bus.rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL sb_ready_in_issue: got rx_ready=%b, need 0", bus.rx_ready);
            end
        end
    end

    function automatic logic [7:0] crc_of(input logic [7:0] q[$]);
        logic [7:0] c = 8'h00;
        for (int i = 1; i < q.size(); i++) begin
            c ^= q[i];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Build frm: A5 cmd addr(LE) data[0..nd-1] crc (optionally corrupted).
    task automatic build(input logic [7:0] c, input logic [31:0] a, input int nd,
                         input logic [511:0] d, input bit bad);
        logic [7:0] crc;
        frm = {};
        frm.push_back(8'hA5);
        frm.push_back(c);
        for (int i = 0; i < 4; i++) frm.push_back(a[8*i +: 8]);
        for (int i = 0; i < nd; i++) frm.push_back(d[8*i +: 8]);
        crc = crc_of(frm);
        frm.push_back(bad ? ~crc : crc);
    endtask

    task automatic expect_txn(input logic [7:0] c, input logic [31:0] a, input int nd,
                              input logic [511:0] d);
        txn_t t;
        t.cmd = c; t.addr = a; t.data = '0;
        for (int i = 0; i < nd; i++) t.data[8*i +: 8] = d[8*i +: 8];
        exp_q.push_back(t);
    endtask

    // Present a byte until it is accepted; returns 1 ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        bus.rx_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_byte_stall: got no accept of %02h in 50 cycles, need accept", b);
        end
    endtask

    task automatic send_frame();
        foreach (frm[i]) send_byte(frm[i]);
    endtask

    // Called right after the CRC byte: start pulse, hold, done, return to IDLE.
    task automatic complete_txn();
        logic [7:0] c0;
        checks++;
        if (bus.start_transaction !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: got start=%b after CRC byte, need 1", bus.start_transaction);
        end
        c0 = bus.cmd;
        @(posedge clk); #1;
        checks++;
        if (bus.start_transaction !== 1'b0 || bus.rx_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_done_state: got start=%b rx_ready=%b busy=%b, need 0 0 1",
                     bus.start_transaction, bus.rx_ready, bus.busy);
        end
        bus.rx_data = 8'hA5; bus.rx_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (bus.rx_ready !== 1'b0 || bus.busy !== 1'b1 || bus.cmd !== c0) begin
            errors++;
            $display("FAIL wait_hold: got rx_ready=%b busy=%b cmd=%02h, need 0 1 %02h",
                     bus.rx_ready, bus.busy, bus.cmd, c0);
        end
        bus.rx_valid = 1'b0;
        bus.transaction_done = 1'b1;
        @(posedge clk); #1;
        bus.transaction_done = 1'b0;
        exp_fcnt++;
        checks++;
        if (bus.busy !== 1'b0 || bus.rx_ready !== 1'b1 || bus.frame_count !== 16'(exp_fcnt)) begin
            errors++;
            $display("FAIL done_return: got busy=%b rx_ready=%b frame_count=%0d, need 0 1 %0d",
                     bus.busy, bus.rx_ready, bus.frame_count, exp_fcnt);
        end
    endtask

    // Called 1 ns after the edge entering ERR.
    task automatic check_err(input string name, input logic [7:0] code);
        checks++;
        if (bus.frame_error !== 1'b1 || bus.error_code !== code) begin
            errors++;
            $display("FAIL %s: got frame_error=%b error_code=%02h, need 1 %02h",
                     name, bus.frame_error, bus.error_code, code);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.frame_error !== 1'b0 || bus.busy !== 1'b0 || bus.rx_ready !== 1'b1 || bus.error_code !== code) begin
            errors++;
            $display("FAIL %s_after: got frame_error=%b busy=%b rx_ready=%b error_code=%02h, need 0 0 1 %02h",
                     name, bus.frame_error, bus.busy, bus.rx_ready, bus.error_code, code);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (bus.rx_ready !== 1'b0 || bus.busy !== 1'b0 || bus.cmd !== 8'h00 || bus.addr !== 32'h0 ||
            bus.start_transaction !== 1'b0 || bus.frame_error !== 1'b0 || bus.error_code !== 8'h00 ||
            bus.frame_count !== 16'h0 || wdata_packed() !== 512'h0) begin
            errors++;
            $display("FAIL %s: got rdy=%b busy=%b cmd=%02h addr=%08h start=%b ferr=%b ec=%02h fc=%0d wd_nonzero=%b, need all 0",
                     name, bus.rx_ready, bus.busy, bus.cmd, bus.addr, bus.start_transaction,
                     bus.frame_error, bus.error_code, bus.frame_count, |wdata_packed());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.transaction_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_values");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got rx_ready=%b, need 1", bus.rx_ready);
        end
    endtask

    task automatic test_write();
        logic [511:0] d = '0;
        d[31:0] = 32'h12345678;
        build(8'h20, 32'h00001020, 4, d, 0);
        expect_txn(8'h20, 32'h00001020, 4, d);
        send_frame();
        complete_txn();
    endtask

    task automatic test_read();
        build(8'hA0, 32'h00001020, 0, '0, 0);
        expect_txn(8'hA0, 32'h00001020, 0, '0);
        send_frame();
        complete_txn();
    endtask

    task automatic test_bad_crc();
        logic [511:0] d = '0;
        d[15:0] = 16'hBEEF;
        build(8'h11, 32'h80000004, 4, d, 1);
`ifdef UART_FRAME_CRC_CHECK_EN
        send_frame();
        check_err("crc_error", 8'h02);
`else
        expect_txn(8'h11, 32'h80000004, 4, d);
        send_frame();
        complete_txn();
`endif
    endtask

    task automatic test_bad_size();
        int s0 = n_start;
        send_byte(8'hA5);
        send_byte(8'h30);
        check_err("bad_size", 8'h01);
        checks++;
        if (n_start != s0) begin
            errors++;
            $display("FAIL bad_size_no_start: got %0d starts, need %0d", n_start, s0);
        end
        send_byte(8'hA5);
        checks++;
        if (bus.error_code !== 8'h00 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL sof_clears_error: got error_code=%02h busy=%b, need 00 1", bus.error_code, bus.busy);
        end
        frm = {8'hA5, 8'h81, 8'h44, 8'h33, 8'h22, 8'h11};
        frm.push_back(crc_of(frm));
        frm.delete(0);
        expect_txn(8'h81, 32'h11223344, 0, '0);
        send_frame();
        complete_txn();
    endtask

    task automatic test_timeout();
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h20);
        repeat (99) begin @(posedge clk); #1; end
        checks++;
        if (bus.frame_error !== 1'b0 || bus.error_code !== 8'h00) begin
            errors++;
            $display("FAIL timeout_early: got frame_error=%b error_code=%02h at cycle 99, need 0 00",
                     bus.frame_error, bus.error_code);
        end
        @(posedge clk); #1;
        check_err("timeout_100", 8'h04);

        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h20);
        repeat (98) begin @(posedge clk); #1; end
        send_byte(8'h10);
        repeat (99) begin @(posedge clk); #1; end
        checks++;
        if (bus.frame_error !== 1'b0 || bus.error_code !== 8'h00 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_restart: got frame_error=%b error_code=%02h busy=%b, need 0 00 1",
                     bus.frame_error, bus.error_code, bus.busy);
        end
        @(posedge clk); #1;
        check_err("timeout_after_restart", 8'h04);
    endtask

    task automatic test_drop_and_max();
        logic [511:0] d;
        logic [7:0] junk [3] = '{8'h00, 8'hFF, 8'h5A};
        foreach (junk[i]) begin
            send_byte(junk[i]);
            checks++;
            if (bus.busy !== 1'b0 || bus.error_code !== 8'h04) begin
                errors++;
                $display("FAIL drop_%02h: got busy=%b error_code=%02h, need 0 04", junk[i], bus.busy, bus.error_code);
            end
        end
        for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i * 7 + 3);
        build(8'h2F, 32'hDEADBEEF, 64, d, 0);
        expect_txn(8'h2F, 32'hDEADBEEF, 64, d);
        send_frame();
        complete_txn();
    endtask

    task automatic test_reset_in_wait();
        logic [511:0] d;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(8'hC0 ^ i);
        build(8'h2F, 32'h00000100, 64, d, 0);
        expect_txn(8'h2F, 32'h00000100, 64, d);
        send_frame();
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (bus.busy !== 1'b1 || bus.addr !== 32'h00000100) begin
            errors++;
            $display("FAIL pre_reset_wait: got busy=%b addr=%08h, need 1 00000100", bus.busy, bus.addr);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_in_wait");
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_fcnt = 0;
        @(posedge clk); #1;
        build(8'hA0, 32'h00000008, 0, '0, 0);
        expect_txn(8'hA0, 32'h00000008, 0, '0);
        send_frame();
        complete_txn();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_crc();
        test_bad_size();
        test_timeout();
        test_drop_and_max();
        test_reset_in_wait();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d unissued frames, need 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
